// File: rtl/mux_2x1.sv
// mux_2x1: word-wide 2:1 selector with optional output register for the datapath
module mux_2x1 #(
  parameter int               WIDTH      = 32,
  parameter bit               REGISTERED = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  output logic             sel_q
);
  logic [WIDTH-1:0] w_mux;
  assign w_mux = sel ? b : a;
  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] r_o;
      logic             r_valid;
      logic             r_sel;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_o     <= RST_VAL;
          r_valid <= 1'b0;
          r_sel   <= 1'b0;
        end else if (en) begin
          r_o     <= w_mux;
          r_valid <= 1'b1;
          r_sel   <= sel;
        end
      end
      assign o       = r_o;
      assign o_valid = r_valid;
      assign sel_q   = r_sel;
    end else begin : g_comb
      assign o       = w_mux;
      assign o_valid = 1'b1;
      assign sel_q   = sel;
    end
  endgenerate
  // an unknown select on a capturing edge is a datapath control bug upstream
  a_sel_known: assert property (@(posedge clk) (en && !rst) |-> !$isunknown(sel))
    else $error("mux_2x1: sel is X/Z on an enabled edge");
endmodule

// File: tb/tb_mux_2x1.sv
// tb_mux_2x1: scoreboard bench for the registered and combinational mux_2x1 builds
module tb_mux_2x1;
  typedef struct packed {
    logic [31:0] o;
    logic        v;
    logic        s;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sel = 1'b0;
  logic [31:0] o;
  logic        o_valid;
  logic        sel_q;
  logic        c_en = 1'b0;
  logic [31:0] c_a = '0;
  logic [31:0] c_b = '0;
  logic        c_sel = 1'b0;
  logic [31:0] c_o;
  logic        c_valid;
  logic        c_sel_q;
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  logic [31:0] m_o = '0;
  logic        m_v = 1'b0;
  logic        m_s = 1'b0;
  mux_2x1 #(.WIDTH(32), .REGISTERED(1'b1), .RST_VAL(32'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .sel(sel),
    .o(o), .o_valid(o_valid), .sel_q(sel_q)
  );
  mux_2x1 #(.WIDTH(32), .REGISTERED(1'b0), .RST_VAL(32'h0)) dut_c (
    .clk(clk), .rst(rst), .en(c_en), .a(c_a), .b(c_b), .sel(c_sel),
    .o(c_o), .o_valid(c_valid), .sel_q(c_sel_q)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [31:0] ia, input logic [31:0] ib, input logic s);
    exp_t x;
    rst = r; en = e; a = ia; b = ib; sel = s;
    if (r) begin
      m_o = 32'h0; m_v = 1'b0; m_s = 1'b0;
    end else if (e) begin
      m_o = s ? ib : ia; m_v = 1'b1; m_s = s;
    end
    sb.push_back('{m_o, m_v, m_s});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check({tag, "_o"}, o, x.o);
      check({tag, "_valid"}, {31'd0, o_valid}, {31'd0, x.v});
      check({tag, "_selq"}, {31'd0, sel_q}, {31'd0, x.s});
    end
  endtask
  initial begin
    step("rst1", 1, 0, 32'h0, 32'h0, 0);
    step("rst2", 1, 1, 32'h0, 32'h0, 0);
    step("sel_b_1", 0, 1, 32'h0, 32'h1, 1);
    step("dead_a", 0, 1, 32'hDEADBEEF, 32'h12345678, 0);
    step("dead_b", 0, 1, 32'hDEADBEEF, 32'h12345678, 1);
    step("load_ff", 0, 1, 32'hFFFFFFFF, 32'h0, 0);
    for (int i = 0; i < 5; i++)
      step("hold", 0, 0, $urandom, $urandom, i[0]);
    step("rst_en_same", 1, 1, 32'h0, 32'h5, 1);
    step("post_rst_hold", 0, 0, 32'hA, 32'hB, 1);
    step("reload", 0, 1, 32'hA, 32'hB, 1);
    step("eq_s0", 0, 1, 32'h5A5A5A5A, 32'h5A5A5A5A, 0);
    step("eq_s1", 0, 1, 32'h5A5A5A5A, 32'h5A5A5A5A, 1);
    for (int i = 0; i < 30; i++)
      step("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           $urandom, $urandom, $urandom_range(0, 1) == 1);
    c_a = 32'h7; c_b = 32'h9;
    for (int i = 0; i < 4; i++) begin
      c_sel = i[0];
      #1;
      check("comb_o", c_o, i[0] ? 32'h9 : 32'h7);
      check("comb_selq", {31'd0, c_sel_q}, {31'd0, i[0]});
      check("comb_valid", {31'd0, c_valid}, 32'd1);
    end
    c_a = 32'hCAFE0000; c_b = 32'h0000F00D; c_sel = 1'b1;
    #1;
    check("comb_wide", c_o, 32'h0000F00D);
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
